// File: rtl/fetch_sequencer_pkg.sv
// Shared front-end definitions: decode modes, run states and defaults.
package Definitions;

    typedef enum logic [1:0] {
        MODE_REG = 2'b00,
        MODE_TGT = 2'b01,
        MODE_IMM = 2'b10,
        MODE_NOP = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } run_t;

    localparam int PC_W_DEF = 10;

endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge Clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// Clocked front end: PC, decode-mode and previous-instruction registers
// plus the IDLE/RUN/HALT run FSM with the Start/Done handshake.
module fetch_sequencer
    import Definitions::*;
#(
    parameter int PC_W       = PC_W_DEF,
    parameter int START_ADDR = 0,
    parameter int CYC_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             BranchEn,
    input  logic [8:0]       BranchTarget,
    input  logic [1:0]       NextState,
    input  logic [8:0]       PrevInstructionOut,
    input  logic             Ack,
    output logic [PC_W-1:0]  ProgCtr,
    output logic [1:0]       CurrState,
    output logic [8:0]       PrevInstruction,
    output logic             Running,
    output logic             Done,
    output logic [CYC_W-1:0] CycleCount
);

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    run_t            r_state;
    logic [PC_W-1:0] r_pc;
    mode_t           r_mode;
    logic [8:0]      r_prev;

    logic [PC_W-1:0] w_tgt;
    logic            w_cnt_clr;
    logic            w_cnt_en;

    // Zero-extends or truncates the 9-bit target to the PC width.
    assign w_tgt = PC_W'(BranchTarget);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_pc    <= START_PC;
            r_mode  <= MODE_REG;
            r_prev  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_pc   <= START_PC;
                    r_mode <= MODE_REG;
                    r_prev <= '0;
                    if (!Start) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (Start) begin
                        r_state <= IDLE;
                        r_pc    <= START_PC;
                        r_mode  <= MODE_REG;
                        r_prev  <= '0;
                    end else if (Ack) begin
                        r_state <= HALT;
                    end else begin
                        r_pc   <= BranchEn ? w_tgt
                                           : r_pc + PC_W'(1);
                        r_mode <= mode_t'(NextState);
                        r_prev <= PrevInstructionOut;
                    end
                end
                HALT: begin
                    if (Start) begin
                        r_state <= IDLE;
                        r_pc    <= START_PC;
                        r_mode  <= MODE_REG;
                        r_prev  <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Any Start request leads to IDLE, so the count clears with it.
    assign w_cnt_clr = Reset || (r_state == IDLE) || Start;
    assign w_cnt_en  = (r_state == RUN);

    sat_counter #(
        .WIDTH(CYC_W)
    ) u_cyc (
        .Clk    (Clk),
        .i_clr  (w_cnt_clr),
        .i_en   (w_cnt_en),
        .o_count(CycleCount)
    );

    assign ProgCtr         = r_pc;
    assign CurrState       = r_mode;
    assign PrevInstruction = r_prev;
    assign Running         = (r_state == RUN);
    assign Done            = (r_state == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer.
module tb_fetch_sequencer;

    logic        Clk = 1'b0;
    logic        Reset, Start, BranchEn, Ack;
    logic [8:0]  BranchTarget, PrevInstructionOut;
    logic [1:0]  NextState;
    logic [9:0]  ProgCtr;
    logic [1:0]  CurrState;
    logic [8:0]  PrevInstruction;
    logic        Running, Done;
    logic [15:0] CycleCount;

    logic        Reset2, Start2;
    logic        BranchEn2 = 1'b0;
    logic        Ack2 = 1'b0;
    logic [8:0]  BranchTarget2 = '0;
    logic [8:0]  PrevOut2 = '0;
    logic [1:0]  NextState2 = '0;
    logic [3:0]  ProgCtr2;
    logic [1:0]  CurrState2;
    logic [8:0]  PrevInstruction2;
    logic        Running2, Done2;
    logic [3:0]  CycleCount2;

    int passed = 0;
    int total  = 0;

    always #5 Clk = ~Clk;

    fetch_sequencer dut (
        .Clk               (Clk),
        .Reset             (Reset),
        .Start             (Start),
        .BranchEn          (BranchEn),
        .BranchTarget      (BranchTarget),
        .NextState         (NextState),
        .PrevInstructionOut(PrevInstructionOut),
        .Ack               (Ack),
        .ProgCtr           (ProgCtr),
        .CurrState         (CurrState),
        .PrevInstruction   (PrevInstruction),
        .Running           (Running),
        .Done              (Done),
        .CycleCount        (CycleCount)
    );

    fetch_sequencer #(
        .PC_W (4),
        .CYC_W(4)
    ) dut_small (
        .Clk               (Clk),
        .Reset             (Reset2),
        .Start             (Start2),
        .BranchEn          (BranchEn2),
        .BranchTarget      (BranchTarget2),
        .NextState         (NextState2),
        .PrevInstructionOut(PrevOut2),
        .Ack               (Ack2),
        .ProgCtr           (ProgCtr2),
        .CurrState         (CurrState2),
        .PrevInstruction   (PrevInstruction2),
        .Running           (Running2),
        .Done              (Done2),
        .CycleCount        (CycleCount2)
    );

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h",
                    tag, obs, exp);
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic restart();
        Start = 1'b1;
        step();
        Start = 1'b0;
        step();
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b1;
        BranchEn = 1'b0; Ack = 1'b0;
        BranchTarget = '0; NextState = '0;
        PrevInstructionOut = '0;
        Reset2 = 1'b1; Start2 = 1'b1;
        step(2);
        check("rst_pc", ProgCtr, 0);
        check("rst_mode", CurrState, 0);
        check("rst_prev", PrevInstruction, 0);
        check("rst_run", Running, 0);
        check("rst_done", Done, 0);
        check("rst_cnt", CycleCount, 0);

        Reset = 1'b0;
        step();
        check("idle_hold_run", Running, 0);
        Start = 1'b0;
        step();
        check("t1_run", Running, 1);
        check("t1_pc0", ProgCtr, 0);
        check("t1_cnt0", CycleCount, 0);
        step();
        check("t1_pc1", ProgCtr, 1);
        step();
        check("t1_pc2", ProgCtr, 2);
        step();
        check("t1_pc3", ProgCtr, 3);
        check("t1_mode", CurrState, 0);
        check("t1_cnt3", CycleCount, 3);

        step(2);
        check("t2_pc5", ProgCtr, 5);
        BranchEn = 1'b1; BranchTarget = 9'h1F3;
        step();
        check("t2_tgt", ProgCtr, 10'h1F3);
        BranchEn = 1'b0;
        step();
        check("t2_inc", ProgCtr, 10'h1F4);

        restart();
        check("t3_pc0", ProgCtr, 0);
        step(7);
        check("t3_pc7", ProgCtr, 7);
        NextState = 2'b01; PrevInstructionOut = 9'h10D;
        step();
        check("t3_mode", CurrState, 1);
        check("t3_prev", PrevInstruction, 9'h10D);
        check("t3_pc8", ProgCtr, 8);
        NextState = 2'b00; PrevInstructionOut = 9'h0;
        step();
        check("t3_mode0", CurrState, 0);
        check("t3_pc9", ProgCtr, 9);

        restart();
        step(8);
        NextState = 2'b10;
        step();
        check("t6_pc9", ProgCtr, 9);
        check("t6_mode", CurrState, 2);
        NextState = 2'b00;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("t6_rst_pc", ProgCtr, 0);
        check("t6_rst_mode", CurrState, 0);
        check("t6_rst_run", Running, 0);
        check("t6_rst_cnt", CycleCount, 0);

        restart();
        step(3);
        NextState = 2'b01;
        step();
        check("t6b_pc4", ProgCtr, 4);
        NextState = 2'b11;
        Start = 1'b1; Ack = 1'b1; BranchEn = 1'b1;
        BranchTarget = 9'h0AA;
        step();
        check("t6b_pc", ProgCtr, 0);
        check("t6b_mode", CurrState, 0);
        check("t6b_run", Running, 0);
        check("t6b_done", Done, 0);
        check("t6b_cnt", CycleCount, 0);
        Ack = 1'b0; BranchEn = 1'b0; NextState = 2'b00;

        restart();
        step(20);
        check("t4_pc20", ProgCtr, 20);
        Ack = 1'b1; BranchEn = 1'b1; BranchTarget = 9'h005;
        NextState = 2'b11; PrevInstructionOut = 9'h1FF;
        step();
        check("t4_pc_hold", ProgCtr, 20);
        check("t4_done", Done, 1);
        check("t4_run", Running, 0);
        check("t4_cnt", CycleCount, 21);
        check("t4_mode", CurrState, 0);
        check("t4_prev", PrevInstruction, 0);
        step();
        check("t4_frz_pc", ProgCtr, 20);
        check("t4_frz_cnt", CycleCount, 21);
        check("t4_frz_done", Done, 1);
        Ack = 1'b0; BranchEn = 1'b0;
        NextState = 2'b00; PrevInstructionOut = 9'h0;
        Start = 1'b1;
        step();
        check("t4_idle_pc", ProgCtr, 0);
        check("t4_idle_done", Done, 0);
        check("t4_idle_cnt", CycleCount, 0);

        Reset2 = 1'b0; Start2 = 1'b0;
        step();
        check("t5_run", Running2, 1);
        step(15);
        check("t5_pc15", ProgCtr2, 15);
        check("t5_cnt15", CycleCount2, 15);
        step();
        check("t5_wrap", ProgCtr2, 0);
        check("t5_sat", CycleCount2, 15);
        step();
        check("t5_pc1", ProgCtr2, 1);
        check("t5_sat2", CycleCount2, 15);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
